// File: rtl/ctl_axil_pkg.sv
// Shared types and constants for the CTL AXI4-Lite initiator.
// No logic: enum, response codes and default timeout only.
// Imported by the initiator top and its interrupt acknowledger.
package ctl_axil_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/irq_edge_acker.sv
// Rising-edge detect on irq_req; one registered one-hot ack per edge, lowest index first.
// Latency: edge -> pending 1 cycle, pending -> ack pulse 1 cycle per queued bit.
// Backpressure: none; edges queue in pending and one is drained per cycle.
module irq_edge_acker
    import ctl_axil_pkg::*;
#(
    parameter int unsigned IRQ_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IRQ_W-1:0] irq_req,
    output logic [IRQ_W-1:0] irq_ack,
    output logic [IRQ_W-1:0] irq_pending
);

    logic [IRQ_W-1:0] irq_prev;
    logic [IRQ_W-1:0] pending;
    logic [IRQ_W-1:0] rise;
    logic [IRQ_W-1:0] grant;

    assign rise  = irq_req & ~irq_prev;
    // Two's-complement trick isolates the lowest set bit.
    assign grant = pending & (~pending + IRQ_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_prev <= '0;
            pending  <= '0;
            irq_ack  <= '0;
        end else begin
            irq_prev <= irq_req;
            // A fresh edge on the bit being granted re-arms it, so no pulse is lost.
            pending  <= (pending & ~grant) | rise;
            irq_ack  <= grant;
        end
    end

    assign irq_pending = pending;

endmodule

// File: rtl/ctl_axil_initiator.sv
// Single-outstanding AXI4-Lite initiator for a partition's CTL port, plus irq edge acks.
// Latency: cmd -> AR/AW 1 cycle; R/B -> rsp_valid 1 cycle; timeout after TIMEOUT_CYCLES.
// Backpressure: cmd_ready low while busy or while a response awaits rsp_ready.
module ctl_axil_initiator
    import ctl_axil_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned IRQ_W          = 16
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,

    output logic [ADDR_W-1:0] CTL_M_AXI_LITE_araddr,
    output logic [2:0]        CTL_M_AXI_LITE_arprot,
    output logic              CTL_M_AXI_LITE_arvalid,
    input  logic              CTL_M_AXI_LITE_arready,
    input  logic [31:0]       CTL_M_AXI_LITE_rdata,
    input  logic [1:0]        CTL_M_AXI_LITE_rresp,
    input  logic              CTL_M_AXI_LITE_rvalid,
    output logic              CTL_M_AXI_LITE_rready,
    output logic [ADDR_W-1:0] CTL_M_AXI_LITE_awaddr,
    output logic [2:0]        CTL_M_AXI_LITE_awprot,
    output logic              CTL_M_AXI_LITE_awvalid,
    input  logic              CTL_M_AXI_LITE_awready,
    output logic [31:0]       CTL_M_AXI_LITE_wdata,
    output logic [3:0]        CTL_M_AXI_LITE_wstrb,
    output logic              CTL_M_AXI_LITE_wvalid,
    input  logic              CTL_M_AXI_LITE_wready,
    input  logic [1:0]        CTL_M_AXI_LITE_bresp,
    input  logic              CTL_M_AXI_LITE_bvalid,
    output logic              CTL_M_AXI_LITE_bready,

    input  logic [IRQ_W-1:0]  irq_req,
    output logic [IRQ_W-1:0]  irq_ack,
    output logic [IRQ_W-1:0]  irq_pending
);

    localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              arvalid;
    logic              awvalid;
    logic              wvalid;
    logic              aw_done;
    logic              w_done;
    logic              timed_out;
    logic [31:0]       tmo_cnt;

    logic              cmd_fire;
    logic              ar_fire;
    logic              aw_fire;
    logic              w_fire;
    logic              r_beat;
    logic              b_beat;
    logic              bus_beat;
    logic              tmo_hit;

    assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ar_fire   = arvalid && CTL_M_AXI_LITE_arready;
    assign aw_fire   = awvalid && CTL_M_AXI_LITE_awready;
    assign w_fire    = wvalid  && CTL_M_AXI_LITE_wready;

    // R may coincide with the AR handshake; rready is held for the whole RD state.
    assign r_beat    = (state == ST_RD) && CTL_M_AXI_LITE_rvalid;
    assign b_beat    = (state == ST_WR) && CTL_M_AXI_LITE_bvalid && aw_done && w_done;
    assign bus_beat  = r_beat || b_beat;

    // Fires on the edge the counter reaches the limit; a beat in the same cycle wins.
    assign tmo_hit   = TMO_EN && (state != ST_IDLE) && !timed_out && !bus_beat
                       && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = cmd_write ? ST_WR : ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (bus_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid     <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            timed_out   <= 1'b0;
            tmo_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            if (ar_fire) begin
                arvalid <= 1'b0;
            end
            if (aw_fire) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (w_fire) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end

            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                arvalid <= !cmd_write;
                awvalid <= cmd_write;
                wvalid  <= cmd_write;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                tmo_cnt <= '0;
            end else if (state != ST_IDLE) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            // A beat arriving after a timeout was already reported is dropped.
            if (bus_beat) begin
                if (timed_out) begin
                    timed_out <= 1'b0;
                end else begin
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= r_beat ? CTL_M_AXI_LITE_rdata : 32'd0;
                    rsp_resp    <= r_beat ? CTL_M_AXI_LITE_rresp : CTL_M_AXI_LITE_bresp;
                    rsp_timeout <= 1'b0;
                end
            end

            if (tmo_hit) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= 32'd0;
                rsp_resp    <= RESP_SLVERR;
                rsp_timeout <= 1'b1;
                timed_out   <= 1'b1;
            end
        end
    end

    assign CTL_M_AXI_LITE_araddr  = addr_q;
    assign CTL_M_AXI_LITE_arprot  = 3'b000;
    assign CTL_M_AXI_LITE_arvalid = arvalid;
    assign CTL_M_AXI_LITE_rready  = (state == ST_RD);
    assign CTL_M_AXI_LITE_awaddr  = addr_q;
    assign CTL_M_AXI_LITE_awprot  = 3'b000;
    assign CTL_M_AXI_LITE_awvalid = awvalid;
    assign CTL_M_AXI_LITE_wdata   = wdata_q;
    assign CTL_M_AXI_LITE_wstrb   = wstrb_q;
    assign CTL_M_AXI_LITE_wvalid  = wvalid;
    assign CTL_M_AXI_LITE_bready  = (state == ST_WR);

    irq_edge_acker #(
        .IRQ_W (IRQ_W)
    ) u_irq (
        .clk         (clk),
        .resetn      (resetn),
        .irq_req     (irq_req),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending)
    );

endmodule

// File: tb/tb_ctl_axil_initiator.sv
// Directed bench for ctl_axil_initiator: AXI-Lite reads/writes, timeout, irq acks, async reset.
module tb_ctl_axil_initiator;

    localparam int ADDR_W = 32;
    localparam int IRQ_W  = 16;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [2:0]        arprot, awprot;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       rdata, wdata;
    logic [1:0]        rresp, bresp;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]        wstrb;
    logic [IRQ_W-1:0]  irq_req, irq_ack, irq_pending;

    int tests_run    = 0;
    int tests_failed = 0;

    int          aw_hs  = 0;
    int          w_hs   = 0;
    int          rsp_hs = 0;
    int          ack3   = 0;
    logic [31:0] slv_awaddr = '0;
    logic [31:0] slv_wdata  = '0;
    logic [3:0]  slv_wstrb  = '0;

    always #5 clk = ~clk;

    ctl_axil_initiator #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO),
        .IRQ_W          (IRQ_W)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_write              (cmd_write),
        .cmd_addr               (cmd_addr),
        .cmd_wdata              (cmd_wdata),
        .cmd_wstrb              (cmd_wstrb),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_rdata              (rsp_rdata),
        .rsp_resp               (rsp_resp),
        .rsp_timeout            (rsp_timeout),
        .CTL_M_AXI_LITE_araddr  (araddr),
        .CTL_M_AXI_LITE_arprot  (arprot),
        .CTL_M_AXI_LITE_arvalid (arvalid),
        .CTL_M_AXI_LITE_arready (arready),
        .CTL_M_AXI_LITE_rdata   (rdata),
        .CTL_M_AXI_LITE_rresp   (rresp),
        .CTL_M_AXI_LITE_rvalid  (rvalid),
        .CTL_M_AXI_LITE_rready  (rready),
        .CTL_M_AXI_LITE_awaddr  (awaddr),
        .CTL_M_AXI_LITE_awprot  (awprot),
        .CTL_M_AXI_LITE_awvalid (awvalid),
        .CTL_M_AXI_LITE_awready (awready),
        .CTL_M_AXI_LITE_wdata   (wdata),
        .CTL_M_AXI_LITE_wstrb   (wstrb),
        .CTL_M_AXI_LITE_wvalid  (wvalid),
        .CTL_M_AXI_LITE_wready  (wready),
        .CTL_M_AXI_LITE_bresp   (bresp),
        .CTL_M_AXI_LITE_bvalid  (bvalid),
        .CTL_M_AXI_LITE_bready  (bready),
        .irq_req                (irq_req),
        .irq_ack                (irq_ack),
        .irq_pending            (irq_pending)
    );

    // Slave-side bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (awvalid && awready) begin
            aw_hs++;
            slv_awaddr = awaddr;
        end
        if (wvalid && wready) begin
            w_hs++;
            slv_wdata = wdata;
            slv_wstrb = wstrb;
        end
        if (rsp_valid && rsp_ready) rsp_hs++;
        if (irq_ack[3]) ack3++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue_cmd_ready: got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        irq_req = 16'h0100;
        repeat (3) tick();
        tests_run++;
        if ({arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_timeout} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_timeout});
        end
        tests_run++;
        if ({rsp_rdata, rsp_resp, arprot, awprot} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0", {rsp_rdata, rsp_resp, arprot, awprot});
        end
        tests_run++;
        if ({irq_ack, irq_pending} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_irq: got %h want 0", {irq_ack, irq_pending});
        end
        resetn = 1'b1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        // irq_req already high at release counts as an edge.
        tick();
        tests_run++;
        if (irq_pending !== 16'h0100) begin
            tests_failed++;
            $display("FAIL reset_irq_edge: got %h want 0100", irq_pending);
        end
        irq_req = '0;
        tick();
        tests_run++;
        if (irq_ack !== 16'h0100) begin
            tests_failed++;
            $display("FAIL reset_irq_ack: got %h want 0100", irq_ack);
        end
        tick();
    endtask

    task automatic test_write_late_wready();
        int aw0 = aw_hs;
        int w0  = w_hs;
        issue(1'b1, 32'h0000_000C, 32'h0000_0001, 4'hF);
        tests_run++;
        if ({awvalid, wvalid, bready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL wr_issue: got %b want 111", {awvalid, wvalid, bready});
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        tests_run++;
        if ({awvalid, wvalid} !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_aw_only: got %b want 01", {awvalid, wvalid});
        end
        tick();
        wready = 1'b1;
        tick();
        wready = 1'b0;
        tests_run++;
        if (wvalid !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_w_done: got %b want 00", {wvalid, rsp_valid});
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, cmd_ready} !== {4'b1000, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL wr_rsp: got %b/%b/%b/%h/%b want 1/0/00/0/0",
                     rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, cmd_ready);
        end
        tests_run++;
        if ((aw_hs - aw0) !== 1 || (w_hs - w0) !== 1) begin
            tests_failed++;
            $display("FAIL wr_hs_count: got aw=%0d w=%0d want 1 1", aw_hs - aw0, w_hs - w0);
        end
        tests_run++;
        if ({slv_awaddr, slv_wdata, slv_wstrb} !== {32'h0C, 32'h1, 4'hF}) begin
            tests_failed++;
            $display("FAIL wr_slave_saw: got %h %h %h want 0000000c 00000001 f",
                     slv_awaddr, slv_wdata, slv_wstrb);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_rsp_hs: got %b%b want 01", rsp_valid, cmd_ready);
        end
        // Read back through a slave that answers R in the AR handshake cycle.
        issue(1'b0, 32'h0000_000C, 32'h0, 4'h0);
        tests_run++;
        if ({arvalid, rready, araddr} !== {2'b11, 32'h0C}) begin
            tests_failed++;
            $display("FAIL rdback_ar: got %b%b %h want 11 0000000c", arvalid, rready, araddr);
        end
        arready = 1'b1; rvalid = 1'b1; rdata = slv_wdata; rresp = 2'b00;
        tick();
        arready = 1'b0; rvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, arvalid, rsp_rdata} !== {2'b10, 32'h1}) begin
            tests_failed++;
            $display("FAIL rdback_rsp: got %b%b %h want 10 00000001", rsp_valid, arvalid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        tests_run++;
        if ({rsp_valid, arvalid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_after_ar: got %b want 00", {rsp_valid, arvalid});
        end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        tests_run++;
        if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {4'b1000, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL rd_rsp: got %b/%b/%b/%h want 1/0/00/deadbeef",
                     rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
        end
        tick();
        tests_run++;
        if ({rsp_valid, rsp_rdata, cmd_ready} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL rd_hold: got %b %h %b want 1 deadbeef 0", rsp_valid, rsp_rdata, cmd_ready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        int bad = 0;
        int h0;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        arready = 1'b1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
            arready = 1'b0;
        end
        tests_run++;
        if (n !== TMO) begin
            tests_failed++;
            $display("FAIL tmo_latency: got %0d cycles want %0d", n, TMO);
        end
        tests_run++;
        if ({rsp_resp, rsp_timeout, rsp_rdata, cmd_ready} !== {3'b101, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL tmo_rsp: got %b/%b/%h/%b want 10/1/0/0",
                     rsp_resp, rsp_timeout, rsp_rdata, cmd_ready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = n + 1; i < 20; i++) begin
            tick();
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL tmo_blocked: got %0d bad cycles want 0", bad);
        end
        h0 = rsp_hs;
        rvalid = 1'b1; rdata = 32'h0000_0055;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        tests_run++;
        if ({rsp_valid, cmd_ready, rready} !== 3'b010) begin
            tests_failed++;
            $display("FAIL tmo_late_beat: got %b want 010", {rsp_valid, cmd_ready, rready});
        end
        rsp_ready = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if (rsp_valid !== 1'b0) bad++;
        end
        rsp_ready = 1'b0;
        tests_run++;
        if (bad !== 0 || rsp_hs !== h0) begin
            tests_failed++;
            $display("FAIL tmo_no_second_rsp: got bad=%0d hs=%0d want 0 %0d", bad, rsp_hs, h0);
        end
    endtask

    task automatic test_irq_pair();
        irq_req = 16'h0005;
        tick();
        tests_run++;
        if ({irq_pending, irq_ack} !== {16'h0005, 16'h0000}) begin
            tests_failed++;
            $display("FAIL irq_pair_pend: got %h/%h want 0005/0000", irq_pending, irq_ack);
        end
        tick();
        tests_run++;
        if ({irq_ack, irq_pending} !== {16'h0001, 16'h0004}) begin
            tests_failed++;
            $display("FAIL irq_pair_ack0: got %h/%h want 0001/0004", irq_ack, irq_pending);
        end
        tick();
        tests_run++;
        if ({irq_ack, irq_pending} !== {16'h0004, 16'h0000}) begin
            tests_failed++;
            $display("FAIL irq_pair_ack2: got %h/%h want 0004/0000", irq_ack, irq_pending);
        end
        tick();
        tests_run++;
        if (irq_ack !== 16'h0000) begin
            tests_failed++;
            $display("FAIL irq_pair_quiet: got %h want 0000", irq_ack);
        end
        irq_req = '0;
        tick();
    endtask

    task automatic test_irq_regrant();
        int c0 = ack3;
        irq_req = 16'h000B;
        tick();
        irq_req = 16'h0003;
        tick();
        tick();
        // Bit 3 rises again on the edge that grants it.
        irq_req = 16'h000B;
        tick();
        tests_run++;
        if ({irq_ack, irq_pending} !== {16'h0008, 16'h0008}) begin
            tests_failed++;
            $display("FAIL irq_regrant_keep: got %h/%h want 0008/0008", irq_ack, irq_pending);
        end
        tick();
        tests_run++;
        if ({irq_ack, irq_pending} !== {16'h0008, 16'h0000}) begin
            tests_failed++;
            $display("FAIL irq_regrant_second: got %h/%h want 0008/0000", irq_ack, irq_pending);
        end
        repeat (3) tick();
        tests_run++;
        if ((ack3 - c0) !== 2) begin
            tests_failed++;
            $display("FAIL irq_regrant_count: got %0d pulses want 2", ack3 - c0);
        end
        irq_req = '0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        issue(1'b1, 32'h0000_0030, 32'h0000_CAFE, 4'h3);
        tests_run++;
        if ({awvalid, wvalid} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rstmid_pre: got %b want 11", {awvalid, wvalid});
        end
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rstmid_drop: got %b want 000", {awvalid, wvalid, bready});
        end
        tick();
        tick();
        resetn = 1'b1;
        issue(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_resp, rsp_timeout, slv_wdata, slv_awaddr} !==
            {4'b1000, 32'hA5A5_A5A5, 32'h20}) begin
            tests_failed++;
            $display("FAIL rstmid_recover: got %b/%b/%b %h %h want 1/00/0 a5a5a5a5 00000020",
                     rsp_valid, rsp_resp, rsp_timeout, slv_wdata, slv_awaddr);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_idle: got %b want 1", cmd_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_late_wready();
        test_read_zero_wait();
        test_timeout();
        test_irq_pair();
        test_irq_regrant();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ctl_axil_initiator.md
Name: ctl_axil_initiator

Overview:
- Shell-side driver of a partition's CTL AXI4-Lite slave port and receiver of its `irq_req` lines.
- Turns single-beat commands from shell logic into AXI4-Lite reads and writes, with one transaction outstanding and a response timeout.
- Turns each rising edge of `irq_req[i]` into exactly one single-cycle `irq_ack[i]` pulse back to the partition.

Parameters:
- `ADDR_W`, 32, CTL address width.
- `TIMEOUT_CYCLES`, 1024, bus cycles before a command is reported as timed out; 0 disables the timeout.
- `IRQ_W`, 16, number of interrupt lines.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`, `cmd_ready`  in/out  1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  `ADDR_W`  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  write strobes.
- `rsp_valid`, `rsp_ready`  out/in  1  response handshake.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_resp`  out  2  AXI response code.
- `rsp_timeout`  out  1  set when the response was produced by the timeout.
- `CTL_M_AXI_LITE_{araddr,arvalid,arready,rdata,rresp,rvalid,rready,awaddr,awvalid,awready,wdata,wstrb,wvalid,wready,bresp,bvalid,bready}`  AXI4-Lite master; data 32 bits, prot driven 3'b000.
- `irq_req`  in  `IRQ_W`  level requests from the partition.
- `irq_ack`  out  `IRQ_W`  one-cycle acknowledge pulses.
- `irq_pending`  out  `IRQ_W`  edges seen but not yet acknowledged.

Behaviour:
- Reset values: all valids, readies, `rsp_*`, `irq_ack` and `irq_pending` are 0. State is IDLE. `irq_prev` is 0, so an `irq_req` already high when reset releases counts as an edge.
- `cmd_ready` = (state == IDLE) && !`rsp_valid`.
- Commands are captured on the `cmd_valid` && `cmd_ready` handshake.
- State RD:
  - `arvalid` asserts the cycle after capture and holds until `arready`.
  - `rready` is held at 1 while in RD.
  - The R beat may arrive in the same cycle as the AR handshake (never earlier); the FSM must accept it.
- State WR:
  - `awvalid` and `wvalid` assert together.
  - Each deasserts independently on its own handshake, tracked by flags `aw_done` and `w_done`.
  - The master never waits for `wready` before asserting `awvalid`; a slave that raises `wready` only after AW must complete.
  - `bready` is held at 1 while in WR.
  - A B beat is accepted only once both `aw_done` and `w_done` are set.
- Completion: a bus beat loads `rsp_rdata` (reads) and `rsp_resp`, sets `rsp_valid`, clears `rsp_timeout`, and returns to IDLE.
- Command-to-AR/AW latency is 1 cycle. With a zero-wait slave, R/B-to-`rsp_valid` latency is 1 cycle.
- `rsp_*` hold stable until `rsp_ready`. A new command cannot be accepted until the response handshake completes.
- Timeout:
  - A 32-bit counter clears on capture and increments every cycle in RD or WR.
  - When it reaches `TIMEOUT_CYCLES` with the beat absent: set `rsp_valid` with `rsp_resp` = 2'b10, `rsp_rdata` = 0, `rsp_timeout` = 1, and set sticky flag `timed_out`.
  - The bus side keeps its valids asserted as AXI requires.
  - When the late beat arrives with `timed_out` set, it is discarded, the FSM returns to IDLE and `timed_out` clears.
  - `cmd_ready` stays 0 throughout.
- Simultaneous events: if the beat arrives in the same cycle the counter hits the limit, the beat wins and no timeout is reported.
- IRQ handling:
  - Edge detection: `edge` = `irq_req` & ~`irq_prev`.
  - Each cycle the lowest-index set bit of `irq_pending` is acknowledged: `irq_ack` is a registered one-hot pulse and that bit clears.
  - Next state: `pending_next` = (`pending` & ~`grant`) | `edge`. An edge on the granted bit in the same cycle keeps it pending, so no pulse is lost.
  - The number of `irq_ack[i]` pulses equals the number of rising edges of `irq_req[i]`.
- Asynchronous reset mid-transaction drops all valids immediately. Bus-side recovery is the system's responsibility.

Decomposition:
- Package `ctl_axil_pkg`:
  - FSM state enum (IDLE, RD, WR).
  - `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10.
  - Default `TIMEOUT_CYCLES`.
- Sub-module `irq_edge_acker` holds the edge detect, pending register and priority grant. The top module holds the AXI FSM.

Test Plan:
- Write 0x1 to 0x0C with strobe 0xF, slave raising `wready` 2 cycles after AW → AW and W each handshake once, `rsp_resp` = 0, then a read of 0x0C returns what the slave stored.
- Read 0x08 with zero-wait slave, `rdata` = 0xDEADBEEF → `rsp_valid` 1 cycle after R, `rsp_rdata` = 0xDEADBEEF, `rsp_timeout` = 0.
- `TIMEOUT_CYCLES` = 8, slave withholds `rvalid` for 20 cycles → timeout response at cycle 8 with resp 2'b10; `cmd_ready` stays 0 until R arrives; no second response.
- `irq_req` = 0x0005 rising in one cycle → `irq_ack` = 0x0001, then 0x0004 on consecutive cycles; `irq_pending` = 0 afterwards.
- `irq_req[3]` toggled 0→1→0→1 with the second edge landing on its grant cycle → exactly two `irq_ack[3]` pulses.
- `resetn` low during WR with `awvalid` high → `awvalid` and `wvalid` drop asynchronously; after release the next command completes normally.
